// File: rtl/mod_99_4_7_verify_ctrl_if.sv
// MAC Merge verify controller signal bundle: receive decoder, transmit arbiter and management.
// master drives the controller inputs; slave is the controller itself.
interface mod_99_4_7_verify_ctrl_if;
  logic       p_enable;
  logic       disable_verify;
  logic       link_fail;
  logic [6:0] verify_time;
  logic       rcv_verify;
  logic       rcv_respond;
  logic       tx_verify_ack;
  logic       tx_respond_ack;
  logic       tx_verify_req;
  logic       tx_respond_req;
  logic [2:0] verify_status;
  logic       preempt_active;
  logic [2:0] verify_cnt;
  logic       verify_timer_done;

  modport master (
    output p_enable, disable_verify, link_fail, verify_time,
           rcv_verify, rcv_respond, tx_verify_ack, tx_respond_ack,
    input  tx_verify_req, tx_respond_req, verify_status, preempt_active,
           verify_cnt, verify_timer_done
  );

  modport slave (
    input  p_enable, disable_verify, link_fail, verify_time,
           rcv_verify, rcv_respond, tx_verify_ack, tx_respond_ack,
    output tx_verify_req, tx_respond_req, verify_status, preempt_active,
           verify_cnt, verify_timer_done
  );
endinterface

// File: rtl/mod_99_4_7_verify_ctrl.sv
// MAC Merge verify/respond controller: verify state diagram, ms verify_timer,
// attempt counting and respond-request generation for the preemption path.
//
// state      | meaning
// S_INIT     | verify_cnt cleared, status INITIAL
// S_DISABLED | verification skipped, preemption allowed
// S_IDLE     | about to request a verify mPacket
// S_SEND     | tx_verify_req held until acked
// S_WAIT     | verify_timer running, waiting for respond
// S_VERIFIED | respond seen, preemption allowed
// S_FAILED   | attempt limit exhausted
module mod_99_4_7_verify_ctrl #(
  parameter int CYCLES_PER_MS = 125000,
  parameter int VERIFY_LIMIT  = 3
) (
  input logic clk,
  input logic reset,
  mod_99_4_7_verify_ctrl_if.slave bus
);

  localparam int         PW     = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CYCLES_PER_MS - 1);
  localparam logic [2:0] LIMIT  = 3'(VERIFY_LIMIT);

  typedef enum logic [2:0] {
    S_INIT,
    S_DISABLED,
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_VERIFIED,
    S_FAILED
  } state_t;

  state_t        state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic [PW-1:0] pre;
  logic [6:0]    ms;
  logic [6:0]    t_lat;
  logic          resp_req;
  logic          abort;
  logic          timer_start;
  logic          timer_done;

  assign abort = bus.link_fail | ~bus.p_enable;

  // t_lat of 0 wraps to 127 here, giving the 128 ms encoding for free
  assign timer_done = (state == S_WAIT) && (pre == PRE_TC) && (ms == t_lat - 7'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    timer_start = 1'b0;
    if (abort) begin
      state_n = S_INIT;
    end else begin
      case (state)
        S_INIT:     state_n = bus.disable_verify ? S_DISABLED : S_IDLE;
        S_DISABLED: if (!bus.disable_verify) state_n = S_INIT;
        S_IDLE:     state_n = bus.disable_verify ? S_INIT : S_SEND;
        S_SEND: begin
          if (bus.disable_verify) begin
            state_n = S_INIT;
          end else if (bus.tx_verify_ack) begin
            state_n     = S_WAIT;
            timer_start = 1'b1;
            cnt_n       = (cnt == 3'd7) ? cnt : cnt + 3'd1;
          end
        end
        S_WAIT: begin
          if (bus.disable_verify)   state_n = S_INIT;
          else if (bus.rcv_respond) state_n = S_VERIFIED;
          else if (timer_done)      state_n = (cnt < LIMIT) ? S_IDLE : S_FAILED;
        end
        S_VERIFIED, S_FAILED: if (bus.disable_verify) state_n = S_INIT;
        default:    state_n = S_INIT;
      endcase
    end
    if (state_n == S_INIT) cnt_n = '0;
  end

  // verify_time is captured once at start so later edits cannot move the expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      pre   <= '0;
      ms    <= '0;
      t_lat <= '0;
    end else if (abort || timer_start) begin
      pre <= '0;
      ms  <= '0;
      if (timer_start) t_lat <= bus.verify_time;
    end else if (state == S_WAIT) begin
      if (pre == PRE_TC) begin
        pre <= '0;
        ms  <= ms + 7'd1;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  // a verify arriving with the ack re-arms the request for one more respond
  always_ff @(posedge clk) begin
    if (reset || abort)          resp_req <= 1'b0;
    else if (bus.rcv_verify)     resp_req <= 1'b1;
    else if (bus.tx_respond_ack) resp_req <= 1'b0;
  end

  always_comb begin
    bus.verify_status  = 3'd0;
    bus.preempt_active = 1'b0;
    case (state)
      S_DISABLED: begin
        bus.verify_status  = 3'd4;
        bus.preempt_active = 1'b1;
      end
      S_IDLE, S_SEND, S_WAIT: bus.verify_status = 3'd1;
      S_VERIFIED: begin
        bus.verify_status  = 3'd2;
        bus.preempt_active = 1'b1;
      end
      S_FAILED:   bus.verify_status = 3'd3;
      default:    bus.verify_status = 3'd0;
    endcase
  end

  assign bus.tx_verify_req     = (state == S_SEND);
  assign bus.tx_respond_req    = resp_req;
  assign bus.verify_cnt        = cnt;
  assign bus.verify_timer_done = timer_done;

endmodule

// File: tb/tb_mod_99_4_7_verify_ctrl.sv
// Bench for the MAC Merge verify controller: directed scenarios plus randomized
// traffic checked against a cycle-count reference model of the verify process.
module tb_mod_99_4_7_verify_ctrl;
  localparam int CPM = 10;
  localparam int LIM = 3;
  localparam int MI = 0, MD = 1, MIDLE = 2, MS = 3, MW = 4, MV = 5, MF = 6;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mod_99_4_7_verify_ctrl_if bus ();
  mod_99_4_7_verify_ctrl_if bus2 ();

  mod_99_4_7_verify_ctrl #(.CYCLES_PER_MS(CPM), .VERIFY_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  mod_99_4_7_verify_ctrl #(.CYCLES_PER_MS(2), .VERIFY_LIMIT(LIM)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  // reference model: phase, attempts, pending respond, absolute expiry cycle
  int     m_st, m_cnt;
  bit     m_resp;
  longint cyc, m_expire;

  function automatic int exp_status();
    case (m_st)
      MD:              return 4;
      MIDLE, MS, MW:   return 1;
      MV:              return 2;
      MF:              return 3;
      default:         return 0;
    endcase
  endfunction

  function automatic bit exp_done();
    return (m_st == MW) && (cyc == m_expire);
  endfunction

  task automatic model_step();
    bit abort = bus.link_fail || !bus.p_enable;
    bit dv    = bus.disable_verify;
    bit expd  = exp_done();
    int nxt   = m_st;
    int t;
    if (reset) begin
      m_st = MI; m_cnt = 0; m_resp = 0; cyc++;
      return;
    end
    if (abort) m_resp = 0;
    else if (bus.rcv_verify) m_resp = 1;
    else if (bus.tx_respond_ack) m_resp = 0;
    if (abort) nxt = MI;
    else begin
      case (m_st)
        MI:    nxt = dv ? MD : MIDLE;
        MD:    if (!dv) nxt = MI;
        MIDLE: nxt = dv ? MI : MS;
        MS: begin
          if (dv) nxt = MI;
          else if (bus.tx_verify_ack) begin
            nxt = MW;
            if (m_cnt < 7) m_cnt++;
            t = (bus.verify_time == 0) ? 128 : int'(bus.verify_time);
            m_expire = cyc + t * CPM;
          end
        end
        MW: begin
          if (dv) nxt = MI;
          else if (bus.rcv_respond) nxt = MV;
          else if (expd) nxt = (m_cnt < LIM) ? MIDLE : MF;
        end
        default: if (dv) nxt = MI;
      endcase
    end
    if (nxt == MI) m_cnt = 0;
    m_st = nxt;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic quiet_inputs();
    bus.rcv_verify = 0; bus.rcv_respond = 0;
    bus.tx_verify_ack = 0; bus.tx_respond_ack = 0; bus.link_fail = 0;
  endtask

  task automatic do_reset(input bit dv);
    quiet_inputs();
    bus.p_enable = 1; bus.disable_verify = dv; bus.verify_time = 7'd2;
    reset = 1; ticks(3); reset = 0;
  endtask

  task automatic wait_req(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (bus.tx_verify_req) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic ack_verify();
    tick();
    bus.tx_verify_ack = 1; tick(); bus.tx_verify_ack = 0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    bus.p_enable = 1; bus.disable_verify = 0; bus.verify_time = 7'd2;
    reset = 1; ticks(3);
    checks++; if (bus.tx_verify_req !== 1'b0) begin errors++; $display("FAIL reset_vreq got %0b want 0", bus.tx_verify_req); end
    checks++; if (bus.tx_respond_req !== 1'b0) begin errors++; $display("FAIL reset_rreq got %0b want 0", bus.tx_respond_req); end
    checks++; if (bus.verify_status !== 3'd0) begin errors++; $display("FAIL reset_status got %0d want 0", bus.verify_status); end
    checks++; if (bus.preempt_active !== 1'b0) begin errors++; $display("FAIL reset_preempt got %0b want 0", bus.preempt_active); end
    checks++; if (bus.verify_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.verify_cnt); end
    checks++; if (bus.verify_timer_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.verify_timer_done); end
    reset = 0;
  endtask

  task automatic test_verify_success();
    bit ok;
    bit seen = 0;
    do_reset(0);
    wait_req(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL succ_wait_req got timeout want request"); end
    ack_verify();
    ticks(4);
    bus.rcv_respond = 1; tick(); bus.rcv_respond = 0;
    checks++; if (bus.verify_status !== 3'd2) begin errors++; $display("FAIL succ_status got %0d want 2", bus.verify_status); end
    checks++; if (bus.verify_cnt !== 3'd1) begin errors++; $display("FAIL succ_cnt got %0d want 1", bus.verify_cnt); end
    checks++; if (bus.preempt_active !== 1'b1) begin errors++; $display("FAIL succ_preempt got %0b want 1", bus.preempt_active); end
    for (int i = 0; i < 30; i++) begin tick(); if (bus.tx_verify_req) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL succ_req_after got 1 want 0"); end
  endtask

  task automatic test_verify_fail();
    bit ok;
    int n;
    do_reset(0);
    for (int a = 1; a <= 3; a++) begin
      wait_req(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fail_wait_req%0d got timeout want request", a); end
      ack_verify();
      n = 1;
      while (!bus.verify_timer_done && n < 40) begin tick(); n++; end
      checks++; if (n != 20) begin errors++; $display("FAIL fail_timer%0d got %0d cycles want 20", a, n); end
      tick();
      checks++; if (bus.verify_timer_done !== 1'b0) begin errors++; $display("FAIL fail_pulse%0d got 1 want 0", a); end
    end
    checks++; if (bus.verify_status !== 3'd3) begin errors++; $display("FAIL fail_status got %0d want 3", bus.verify_status); end
    checks++; if (bus.verify_cnt !== 3'd3) begin errors++; $display("FAIL fail_cnt got %0d want 3", bus.verify_cnt); end
    checks++; if (bus.preempt_active !== 1'b0) begin errors++; $display("FAIL fail_preempt got %0b want 0", bus.preempt_active); end
    ticks(10);
    checks++; if (bus.tx_verify_req !== 1'b0 || bus.verify_status !== 3'd3) begin
      errors++; $display("FAIL fail_terminal got req %0b status %0d want 0/3", bus.tx_verify_req, bus.verify_status); end
  endtask

  task automatic test_respond_on_expiry();
    bit ok;
    bit seen = 0;
    do_reset(0);
    for (int a = 1; a <= 2; a++) begin
      wait_req(40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rexp_wait_req%0d got timeout want request", a); end
      ack_verify();
      ticks(19);
      checks++; if (bus.verify_timer_done !== 1'b1) begin errors++; $display("FAIL rexp_done%0d got 0 want 1", a); end
      if (a == 2) begin bus.rcv_respond = 1; tick(); bus.rcv_respond = 0; end
      else tick();
    end
    checks++; if (bus.verify_status !== 3'd2) begin errors++; $display("FAIL rexp_status got %0d want 2", bus.verify_status); end
    checks++; if (bus.verify_cnt !== 3'd2) begin errors++; $display("FAIL rexp_cnt got %0d want 2", bus.verify_cnt); end
    for (int i = 0; i < 40; i++) begin tick(); if (bus.tx_verify_req) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL rexp_third_req got 1 want 0"); end
  endtask

  task automatic test_abort();
    bit ok;
    do_reset(0);
    wait_req(10, ok);
    ack_verify();
    ticks(5);
    bus.link_fail = 1; tick(); bus.link_fail = 0;
    checks++; if (bus.verify_status !== 3'd0 || bus.tx_verify_req !== 1'b0 || bus.verify_cnt !== 3'd0) begin
      errors++; $display("FAIL abort_wait got status %0d req %0b cnt %0d want 0/0/0", bus.verify_status, bus.tx_verify_req, bus.verify_cnt); end
    wait_req(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_restart got timeout want request"); end
    ack_verify();
    checks++; if (bus.verify_cnt !== 3'd1) begin errors++; $display("FAIL abort_cnt1 got %0d want 1", bus.verify_cnt); end
    wait_req(40, ok);
    checks++; if (!ok || bus.verify_cnt !== 3'd1) begin errors++; $display("FAIL abort_send_pending got req %0b cnt %0d want 1/1", ok, bus.verify_cnt); end
    bus.link_fail = 1; tick(); bus.link_fail = 0;
    checks++; if (bus.verify_status !== 3'd0 || bus.tx_verify_req !== 1'b0 || bus.verify_cnt !== 3'd0) begin
      errors++; $display("FAIL abort_send got status %0d req %0b cnt %0d want 0/0/0", bus.verify_status, bus.tx_verify_req, bus.verify_cnt); end
    wait_req(10, ok);
    ack_verify();
    checks++; if (!ok || bus.verify_cnt !== 3'd1) begin errors++; $display("FAIL abort_recount got req %0b cnt %0d want 1/1", ok, bus.verify_cnt); end
  endtask

  task automatic test_disabled_respond();
    bit seen = 0;
    do_reset(1);
    for (int i = 0; i < 20; i++) begin tick(); if (bus.tx_verify_req) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL dis_vreq got 1 want 0"); end
    checks++; if (bus.verify_status !== 3'd4 || bus.preempt_active !== 1'b1) begin
      errors++; $display("FAIL dis_status got %0d/%0b want 4/1", bus.verify_status, bus.preempt_active); end
    bus.rcv_verify = 1; tick(); bus.rcv_verify = 0;
    ticks(3);
    checks++; if (bus.tx_respond_req !== 1'b1) begin errors++; $display("FAIL dis_rreq_held got 0 want 1"); end
    bus.tx_respond_ack = 1; tick(); bus.tx_respond_ack = 0;
    checks++; if (bus.tx_respond_req !== 1'b0) begin errors++; $display("FAIL dis_rreq_clear got 1 want 0"); end
    bus.rcv_verify = 1; tick();
    bus.tx_respond_ack = 1; tick(); bus.rcv_verify = 0; bus.tx_respond_ack = 0;
    checks++; if (bus.tx_respond_req !== 1'b1) begin errors++; $display("FAIL dis_rreq_coincident got 0 want 1"); end
    bus.tx_respond_ack = 1; tick(); bus.tx_respond_ack = 0;
    checks++; if (bus.tx_respond_req !== 1'b0) begin errors++; $display("FAIL dis_rreq_second got 1 want 0"); end
    bus.rcv_verify = 1; tick(); tick(); bus.rcv_verify = 0;
    bus.tx_respond_ack = 1; tick(); bus.tx_respond_ack = 0; tick();
    checks++; if (bus.tx_respond_req !== 1'b0) begin errors++; $display("FAIL dis_no_queue got 1 want 0"); end
  endtask

  task automatic test_long_timer();
    bit ok = 0;
    int n;
    do_reset(0);
    bus.p_enable = 0;
    bus2.p_enable = 1; bus2.verify_time = 7'd0;
    for (int i = 0; i < 10 && !ok; i++) begin if (bus2.tx_verify_req) ok = 1; else tick(); end
    checks++; if (!ok) begin errors++; $display("FAIL long_wait_req got timeout want request"); end
    tick(); bus2.tx_verify_ack = 1; tick(); bus2.tx_verify_ack = 0;
    n = 1;
    while (!bus2.verify_timer_done && n < 400) begin
      if (n == 50) bus2.verify_time = 7'd1;
      tick(); n++;
    end
    checks++; if (n != 256) begin errors++; $display("FAIL long_timer got %0d cycles want 256", n); end
    checks++; if (bus2.verify_cnt !== 3'd1) begin errors++; $display("FAIL long_cnt got %0d want 1", bus2.verify_cnt); end
    bus2.p_enable = 0; bus.p_enable = 1;
    tick();
  endtask

  task automatic test_random();
    do_reset(0);
    for (int i = 0; i < 5000; i++) begin
      bus.link_fail      = ($urandom_range(0, 199) == 0);
      if (bus.p_enable) bus.p_enable = ($urandom_range(0, 299) != 0);
      else              bus.p_enable = ($urandom_range(0, 9) == 0);
      if (!bus.disable_verify) bus.disable_verify = ($urandom_range(0, 399) == 0);
      else                     bus.disable_verify = ($urandom_range(0, 19) != 0);
      bus.verify_time    = 7'($urandom_range(1, 3));
      bus.tx_verify_ack  = ($urandom_range(0, 2) == 0);
      bus.tx_respond_ack = ($urandom_range(0, 2) == 0);
      bus.rcv_verify     = ($urandom_range(0, 14) == 0);
      bus.rcv_respond    = ($urandom_range(0, 39) == 0);
      tick();
      checks++; if (bus.verify_status !== 3'(exp_status())) begin errors++; $display("FAIL rand_status cyc %0d got %0d want %0d", i, bus.verify_status, exp_status()); end
      checks++; if (bus.verify_cnt !== 3'(m_cnt)) begin errors++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", i, bus.verify_cnt, m_cnt); end
      checks++; if (bus.tx_verify_req !== (m_st == MS)) begin errors++; $display("FAIL rand_vreq cyc %0d got %0b want %0b", i, bus.tx_verify_req, m_st == MS); end
      checks++; if (bus.tx_respond_req !== m_resp) begin errors++; $display("FAIL rand_rreq cyc %0d got %0b want %0b", i, bus.tx_respond_req, m_resp); end
      checks++; if (bus.preempt_active !== (m_st == MD || m_st == MV)) begin errors++; $display("FAIL rand_preempt cyc %0d got %0b want %0b", i, bus.preempt_active, m_st == MD || m_st == MV); end
      checks++; if (bus.verify_timer_done !== exp_done()) begin errors++; $display("FAIL rand_done cyc %0d got %0b want %0b", i, bus.verify_timer_done, exp_done()); end
    end
    quiet_inputs();
  endtask

  initial begin
    m_st = MI; m_cnt = 0; m_resp = 0; cyc = 0; m_expire = -1;
    reset = 1;
    bus2.p_enable = 0; bus2.disable_verify = 0; bus2.link_fail = 0; bus2.verify_time = 7'd2;
    bus2.rcv_verify = 0; bus2.rcv_respond = 0; bus2.tx_verify_ack = 0; bus2.tx_respond_ack = 0;
    test_reset();
    test_verify_success();
    test_verify_fail();
    test_respond_on_expiry();
    test_abort();
    test_disabled_respond();
    test_long_timer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
